fetch_unit: RTL and testbench

- Instruction fetch stage upstream of the core's decode/execute logic.
- Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small instruction queue and hands {pc, inst} downstream over a valid/ready channel.
- Handles redirects (branch, jump, trap) by flushing the queue and discarding responses still in flight.

---
 rtl/core_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 84 ++++++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: data width, reset/exit constants and the fetch packet.
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [XLEN-1:0] INST_NOP          = 32'h0000_0013;
   // "unimp" encoding, used as the stop marker when the exit feature is built in
   localparam logic [XLEN-1:0] DEFAULT_EXIT_INST = 32'hc000_1073;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_pkt_t;

   // Clear the byte-offset bits of an instruction address.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush. Entries and pointers are registers, so the head
// seen by the consumer only ever changes on a clock edge.
module fetch_queue #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       head_valid,
   output logic [WIDTH-1:0]           head_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [WIDTH-1:0] entry_view [DEPTH];
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Qualify requests: no pop from empty, no push into a full queue unless its head leaves.
   always_comb begin
      do_pop  = pop && (count_reg != '0);
      do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);
   end

   // Pointer and occupancy update; flush empties the queue and ignores push/pop.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
         if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
         if (do_push && !do_pop)      count_next = count_reg + CNT_W'(1);
         else if (!do_push && do_pop) count_next = count_reg - CNT_W'(1);
      end
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [WIDTH-1:0] entry_reg;
         // Storage slot gi, written only when it is the current write target.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                              entry_reg <= '0;
            else if (do_push && !flush && wr_ptr_reg == PTR_W'(gi)) entry_reg <= push_data;
         end
         assign entry_view[gi] = entry_reg;
      end
   endgenerate

   assign count      = count_reg;
   assign head_valid = (count_reg != '0);
   assign head_data  = entry_view[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned imem requests,
// queues in-order responses and hands {pc, inst} downstream.
// Optional build macro FETCH_EXIT_EN adds a sticky 'exit' output that halts
// fetch once EXIT_INST has been consumed downstream.
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int              QDEPTH    = 2,
   parameter int              MAX_OUTST = 2
`ifdef FETCH_EXIT_EN
   ,
   parameter logic [XLEN-1:0] EXIT_INST = DEFAULT_EXIT_INST
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
`ifdef FETCH_EXIT_EN
   ,
   output logic            exit
`endif
);

   localparam int OW = $clog2(MAX_OUTST + 1);
   localparam int QW = $clog2(QDEPTH + 1);

   logic [XLEN-1:0] pc_reg, pc_next;
   logic [OW-1:0]   drop_reg, drop_next;
   logic [OW-1:0]   outst;        // requests accepted, response not yet seen
   logic [QW-1:0]   qcount;
   logic            side_valid;
   logic [XLEN-1:0] side_pc;     // PC of the oldest outstanding request
   logic            q_valid;
   fetch_pkt_t      q_head, q_push_pkt;
   logic            halted;
   logic            pop, req_fire, rsp_pop, rsp_take;
   int              occupancy;

   // Downstream view and request gating. A head leaving this cycle frees its
   // slot before any request issued now can respond, so it counts as free;
   // this is what sustains one instruction per cycle with a 1-cycle memory.
   always_comb begin
      inst_valid     = q_valid && !halted;
      inst           = q_head.inst;
      inst_pc        = q_head.pc;
      pop            = inst_valid && inst_ready;
      occupancy      = int'(outst) + int'(qcount) - int'(pop);
      imem_req_valid = rst_n && !redirect && !halted &&
                       (occupancy < QDEPTH) && (int'(outst) < MAX_OUTST);
      imem_req_addr  = pc_reg;
      req_fire       = imem_req_valid && imem_req_ready;
      rsp_pop        = imem_rsp_valid && side_valid;
      rsp_take       = rsp_pop && (drop_reg == '0) && !redirect;
      q_push_pkt     = '{pc: side_pc, inst: imem_rsp_data};
   end

   // PC advance and stale-response bookkeeping. On redirect every request still
   // in flight after this cycle is stale, so drop becomes the post-cycle outst.
   always_comb begin
      pc_next   = pc_reg;
      drop_next = drop_reg;
      if (redirect) begin
         pc_next   = word_align(redirect_pc);
         drop_next = rsp_pop ? outst - OW'(1) : outst;
      end else begin
         if (req_fire)                     pc_next   = pc_reg + XLEN'(4);
         if (rsp_pop && drop_reg != '0)    drop_next = drop_reg - OW'(1);
      end
   end

   // PC and drop counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg   <= RESET_PC;
         drop_reg <= '0;
      end else begin
         pc_reg   <= pc_next;
         drop_reg <= drop_next;
      end
   end

   // Side FIFO pairing each in-flight request with its address; its fill level is outst.
   fetch_queue #(
      .DEPTH (MAX_OUTST),
      .WIDTH (XLEN)
   ) u_side_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (1'b0),
      .push       (req_fire),
      .push_data  (pc_reg),
      .pop        (rsp_pop),
      .count      (outst),
      .head_valid (side_valid),
      .head_data  (side_pc)
   );

   // Instruction queue feeding downstream; a redirect flushes it.
   fetch_queue #(
      .DEPTH (QDEPTH),
      .WIDTH ($bits(fetch_pkt_t))
   ) u_inst_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect),
      .push       (rsp_take),
      .push_data  (q_push_pkt),
      .pop        (pop),
      .count      (qcount),
      .head_valid (q_valid),
      .head_data  (q_head)
   );

`ifdef FETCH_EXIT_EN
   logic exit_reg;
   // Latch a consumed exit instruction; only reset releases the halt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              exit_reg <= 1'b0;
      else if (pop && q_head.inst == EXIT_INST) exit_reg <= 1'b1;
   end
   assign halted = exit_reg;
   assign exit   = exit_reg;
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with configurable
// latency, and a scoreboard of {pc, inst} packets with epoch-tagged requests.
module tb_fetch_unit;
   import core_pkg::*;

   localparam int QDEPTH    = 2;
   localparam int MAX_OUTST = 2;

   logic        clk = 1'b0;
   logic        rst_n, redirect, imem_req_ready, imem_rsp_valid, inst_ready;
   logic [31:0] redirect_pc, imem_rsp_data;
   logic        imem_req_valid, inst_valid;
   logic [31:0] imem_req_addr, inst, inst_pc;
`ifdef FETCH_EXIT_EN
   logic        exit;
   localparam bit EXIT_EN = 1'b1;
`else
   localparam bit EXIT_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .QDEPTH    (QDEPTH),
      .MAX_OUTST (MAX_OUTST)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc)
`ifdef FETCH_EXIT_EN
      ,
      .exit           (exit)
`endif
   );

   typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] data; } pkt_t;

   mreq_t       mq[$];      // requests in flight inside the memory
   pkt_t        iq[$];      // packets the fetch unit should be holding
   logic [31:0] dlog[$];    // delivered PCs
   int          checks = 0, errors = 0;
   int          cyc = 0, lat = 1, epoch = 0, fire_cnt = 0;
   logic [31:0] fetch_pc, exp_dpc;
   bit          exited, patch_en, obs_iv;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (patch_en && a == 32'h0000_0008) return DEFAULT_EXIT_INST;
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: entered and left at a falling edge.
   task automatic step(input bit rd, input logic [31:0] rpc, input bit rq, input bit ir);
      bit    rsp, exp_iv, exp_req, pop, fire, hs, nxt_exit;
      mreq_t r;
      redirect       = rd;
      redirect_pc    = rpc;
      imem_req_ready = rq;
      inst_ready     = ir;
      rsp            = (mq.size() > 0) && (mq[0].due <= cyc);
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom();
      #1;
      exp_iv  = (iq.size() > 0) && !exited;
      pop     = exp_iv && ir;
      exp_req = !rd && !exited && (mq.size() + iq.size() - int'(pop) < QDEPTH) &&
                (mq.size() < MAX_OUTST);
      obs_iv  = inst_valid;
      check("inst_valid", 32'(inst_valid), 32'(exp_iv));
      if (exp_iv) begin
         check("inst_pc", inst_pc, iq[0].pc);
         check("inst", inst, iq[0].data);
      end
      check("req_valid", 32'(imem_req_valid), 32'(exp_req));
`ifdef FETCH_EXIT_EN
      check("exit", 32'(exit), 32'(exited));
`endif
      fire     = imem_req_valid && rq;
      hs       = inst_valid && ir;
      nxt_exit = EXIT_EN && pop && (iq[0].data == DEFAULT_EXIT_INST);
      if (fire) begin
         check("req_addr", imem_req_addr, fetch_pc);
         fire_cnt++;
      end
      if (hs) begin
         $display("cyc=%0d deliver pc=%08h inst=%08h", cyc, inst_pc, inst);
         check("pc_sequence", inst_pc, exp_dpc);
         exp_dpc = inst_pc + 32'd4;
         dlog.push_back(inst_pc);
         if (iq.size() > 0) void'(iq.pop_front());
      end
      if (rsp) begin
         r = mq.pop_front();
         if (!rd && r.epoch == epoch) iq.push_back('{r.addr, mem_word(r.addr)});
      end
      if (fire) mq.push_back('{imem_req_addr, cyc + lat, epoch});
      if (rd) begin
         iq.delete();
         epoch++;
         fetch_pc = {rpc[31:2], 2'b00};
         exp_dpc  = {rpc[31:2], 2'b00};
      end else if (fire) begin
         fetch_pc = fetch_pc + 32'd4;
      end
      exited = exited | nxt_exit;
      @(negedge clk);
      cyc++;
   endtask

   // Entered at a falling edge; returns at the falling edge that starts the first active cycle.
   task automatic do_reset();
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = INST_NOP; inst_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_inst_pc", inst_pc, 32'd0);
`ifdef FETCH_EXIT_EN
      check("rst_exit", 32'(exit), 32'd0);
`endif
      mq.delete(); iq.delete();
      fetch_pc = 32'h0; exp_dpc = 32'h0; exited = 1'b0; epoch++;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int first_iv, rel, mark, n, k;
      logic [31:0] held_pc;
      patch_en = 1'b0;
      @(negedge clk);
      do_reset();

      // Steady stream from reset: first inst_valid two cycles after release, then 1/cycle.
      rel = cyc; first_iv = -1;
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 1, 1);
         if (obs_iv && first_iv < 0) first_iv = cyc - 1;
      end
      check("first_valid_latency", 32'(first_iv - rel), 32'd2);
      check("throughput", 32'(dlog.size()), 32'd18);
      for (int i = 0; i < 5; i++) check("reset_stream_pc", dlog[i], 32'(i * 4));

      // Downstream stall: head holds, at most QDEPTH extra fetches, nothing lost after.
      fire_cnt = 0;
      step(0, 0, 1, 0);
      held_pc = inst_pc;
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0);
         check("hold_valid", 32'(inst_valid), 32'd1);
         check("hold_pc", inst_pc, held_pc);
      end
      check("stall_fetches", 32'(fire_cnt <= QDEPTH), 32'd1);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

      // Redirect with two stale requests on a 3-cycle memory.
      k = 0;
      while (mq.size() > 0 && k < 20) begin step(0, 0, 0, 1); k++; end
      lat = 3; k = 0;
      while (mq.size() < 2 && k < 20) begin step(0, 0, 1, 1); k++; end
      check("two_outstanding", 32'(mq.size()), 32'd2);
      mark = dlog.size();
      step(1, 32'h0000_0103, 1, 1);
      k = 0;
      while (dlog.size() == mark && k < 30) begin step(0, 0, 1, 1); k++; end
      check("redirect_delivered", 32'(dlog.size() > mark), 32'd1);
      if (dlog.size() > mark) check("redirect_target_pc", dlog[mark], 32'h0000_0100);

      // Redirect coinciding with a response arrival and an inst handshake.
      k = 0;
      while (mq.size() > 0 && k < 20) begin step(0, 0, 0, 1); k++; end
      lat = 1; k = 0;
      while (!((mq.size() > 0) && (mq[0].due <= cyc) && (iq.size() > 0)) && k < 30) begin
         step(0, 0, 1, 1); k++;
      end
      check("collision_setup", 32'(k < 30), 32'd1);
      step(1, 32'h0000_0200, 1, 1);
      #1 check("collision_inst_valid", 32'(inst_valid), 32'd0);
      for (int i = 0; i < 6; i++) step(0, 0, 1, 1);

      // Address wrap with imem_req_ready toggling.
      step(1, 32'hFFFF_FFF8, 1, 1);
      mark = dlog.size(); k = 0;
      while (dlog.size() < mark + 3 && k < 40) begin step(0, 0, k[0], 1); k++; end
      check("wrap_delivered", 32'(dlog.size() >= mark + 3), 32'd1);
      if (dlog.size() >= mark + 3) begin
         check("wrap_pc0", dlog[mark],     32'hFFFF_FFF8);
         check("wrap_pc1", dlog[mark + 1], 32'hFFFF_FFFC);
         check("wrap_pc2", dlog[mark + 2], 32'h0000_0000);
      end

      // Exit instruction at pc 0x8 (halts only when the feature is built in).
      patch_en = 1'b1;
      step(1, 32'h0000_0000, 1, 1);
      mark = dlog.size();
      for (int i = 0; i < 14; i++) step(0, 0, 1, 1);
      n = dlog.size() - mark;
`ifdef FETCH_EXIT_EN
      check("exit_deliveries", 32'(n), 32'd3);
      check("exit_set", 32'(exit), 32'd1);
`else
      check("no_exit_deliveries", 32'(n >= 10), 32'd1);
`endif
      patch_en = 1'b0;
      do_reset();

      // Randomised traffic with redirects, latency changes and an occasional reset.
      for (int i = 0; i < 700; i++) begin
         if (mq.size() == 0 && $urandom_range(0, 15) == 0) lat = $urandom_range(1, 3);
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 19) == 0) begin
            step(1, ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : $urandom(),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         end else begin
            step(0, $urandom(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
